// File: rtl/imem_arbiter_if.sv
// ----------------------------------------------------------------------------
// imem_arbiter_if
// Bundles the fetch-port, loader-port and memory-port signals of the
// instruction-memory arbiter.
//   fetch : f_req, f_addr -> f_gnt, f_rvalid, f_rdata, f_err
//   loader: l_req, l_we, l_addr, l_wdata, l_lock -> l_gnt, l_rvalid, l_rdata, l_err
//   memory: mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// modport slave  : the arbiter side
// modport master : the requesters and the memory array side
// ----------------------------------------------------------------------------
interface imem_arbiter_if #(
    parameter int ADDR_W     = 64,
    parameter int DEPTH_LOG2 = 7
);
    logic                  f_req;
    logic [ADDR_W-1:0]     f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [31:0]           f_rdata;
    logic                  f_err;

    logic                  l_req;
    logic                  l_we;
    logic [ADDR_W-1:0]     l_addr;
    logic [31:0]           l_wdata;
    logic                  l_lock;
    logic                  l_gnt;
    logic                  l_rvalid;
    logic [31:0]           l_rdata;
    logic                  l_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata, f_err,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        output l_gnt, l_rvalid, l_rdata, l_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        input  l_gnt, l_rvalid, l_rdata, l_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter
// Shares a single-ported, synchronous-read instruction memory between the
// core fetch path and the program loader/debug port. At most one memory
// access per cycle; misaligned or out-of-range requests are answered with an
// error response without touching memory. Read data returns one cycle after
// the grant, straight from the memory read port.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - imem_arbiter_if.slave (fetch, loader and memory signals)
// ----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DEPTH_LOG2   = 7,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    imem_arbiter_if.slave     bus
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    // Who owns the read data arriving from memory in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_LOADER
    } owner_t;

    owner_t     owner_q, owner_d;
    logic       f_err_q, f_err_d;
    logic       l_err_q, l_err_d;
    logic [2:0] starve_q, starve_d;

    logic f_bad, l_bad;
    logic f_bad_req, l_bad_req;
    logic f_good_req, l_good_req;
    logic f_win, l_win;
    logic f_gnt_c, l_gnt_c;
    logic mem_en_c, mem_we_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            f_err_q  <= 1'b0;
            l_err_q  <= 1'b0;
            starve_q <= 3'd0;
        end else begin
            owner_q  <= owner_d;
            f_err_q  <= f_err_d;
            l_err_q  <= l_err_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        f_bad      = (bus.f_addr[2:0] != 3'b000) ||
                     (bus.f_addr[ADDR_W-1:DEPTH_LOG2+3] != '0);
        l_bad      = (bus.l_addr[2:0] != 3'b000) ||
                     (bus.l_addr[ADDR_W-1:DEPTH_LOG2+3] != '0);
        f_bad_req  = bus.f_req && f_bad;
        l_bad_req  = bus.l_req && l_bad;
        f_good_req = bus.f_req && !f_bad;
        l_good_req = bus.l_req && !l_bad;

        // Loader wins when locked, when it has been starved long enough, or
        // when fetch has nothing valid to ask for.
        l_win = l_good_req &&
                (bus.l_lock || (starve_q == STARVE_MAX) || !f_good_req);
        f_win = f_good_req && !bus.l_lock && !l_win;

        // Bad requests are answered without arbitration, but the lock still
        // keeps fetch out completely.
        f_gnt_c = f_win || (f_bad_req && !bus.l_lock);
        l_gnt_c = l_win || l_bad_req;

        mem_en_c = !rst && (f_win || l_win);
        mem_we_c = mem_en_c && l_win && bus.l_we;

        owner_d = OWN_NONE;
        if (mem_en_c && !mem_we_c) begin
            owner_d = l_win ? OWN_LOADER : OWN_FETCH;
        end

        f_err_d = f_bad_req && !bus.l_lock;
        l_err_d = l_bad_req;

        // Only good, denied loader requests count toward starvation.
        starve_d = starve_q;
        if (!bus.l_req || l_gnt_c) begin
            starve_d = 3'd0;
        end else if (l_good_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
        end
    end

    assign bus.f_gnt     = f_gnt_c;
    assign bus.l_gnt     = l_gnt_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = l_win ? bus.l_addr[DEPTH_LOG2+2:3]
                                 : bus.f_addr[DEPTH_LOG2+2:3];
    assign bus.mem_wdata = bus.l_wdata;

    // Responses are masked while reset is high so that a read granted just
    // before reset never surfaces.
    assign bus.f_rvalid = !rst && ((owner_q == OWN_FETCH) || f_err_q);
    assign bus.f_err    = !rst && f_err_q;
    assign bus.f_rdata  = (!rst && (owner_q == OWN_FETCH)) ? bus.mem_rdata : 32'd0;

    assign bus.l_rvalid = !rst && ((owner_q == OWN_LOADER) || l_err_q);
    assign bus.l_err    = !rst && l_err_q;
    assign bus.l_rdata  = (!rst && (owner_q == OWN_LOADER)) ? bus.mem_rdata : 32'd0;

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-ported, 32-bit-word instruction memory between two requesters: the core fetch path and the program loader/debug port. Grants at most one memory access per cycle, enforces 8-byte alignment and range, and returns read data one cycle after grant. It sits between the fetch stage, the loader, and a synchronous-read instruction memory array.

Parameters:
ADDR_W, 64, requester byte-address width
DEPTH_LOG2, 7, log2 of memory word count; word index = addr[DEPTH_LOG2+2:3]
STARVE_LIMIT, 4, consecutive loader denials before the loader is forced ahead of fetch (1..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
f_req  in  1  fetch read request
f_addr  in  ADDR_W  fetch byte address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  fetch read data valid
f_rdata  out  32  fetch read data
f_err  out  1  fetch misaligned/out-of-range response
l_req  in  1  loader request
l_we  in  1  loader write (1) / read (0)
l_addr  in  ADDR_W  loader byte address
l_wdata  in  32  loader write data
l_lock  in  1  loader holds exclusive ownership; fetch is never granted
l_gnt  out  1  loader request accepted this cycle
l_rvalid  out  1  loader read data valid
l_rdata  out  32  loader read data
l_err  out  1  loader misaligned/out-of-range response
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  DEPTH_LOG2  memory word index
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Single clock; all state updates on rising clk; rst synchronous active-high.
- Reset: starve counter 0; rvalid/err/rdata registers 0; pending-read owner cleared. Combinational outputs (gnt, mem_*) follow inputs; mem_en = 0 while rst high.
- Request is bad when addr[2:0] != 0 or addr[ADDR_W-1:DEPTH_LOG2+3] != 0.
- Bad requests bypass arbitration: gnt asserted in the same cycle; no memory access; next cycle err = 1, rvalid = 1, rdata = 0. Both requesters may be bad in the same cycle; both are granted.
- Good requests arbitrate combinationally; the winner's gnt is high in the same cycle.
- Winner selection:
  - if l_lock: loader wins;
  - else if starve counter == STARVE_LIMIT: loader wins;
  - else fetch wins if f_req, otherwise loader.
- Fetch is never granted while l_lock is high, even if the loader is idle.
- Winner drives mem_en = 1, mem_addr = word index, mem_we = (loader && l_we), mem_wdata = l_wdata.
- Read latency is 1: the cycle after a granted read, owner's rvalid = 1 and rdata = mem_rdata. The non-owner's rdata = 0. Writes produce no rvalid and no err.
- Starve counter (3-bit):
  - increments, saturating at STARVE_LIMIT, when l_req && good && !l_gnt;
  - clears on l_gnt or !l_req.
- Back-to-back grants are allowed every cycle; rvalid pulses may therefore be continuous.
- Read and write to the same word in consecutive cycles: the read returns whatever the memory presents; there is no forwarding.
- Reset asserted mid-read: the pending rvalid is dropped; no response is delivered after reset.
- Requesters hold req/addr until gnt; behaviour when inputs change without a grant is unconstrained.

Test Plan:
- Reset, then f_req=1, f_addr=0x8 with mem word1=0x00000063 -> f_gnt same cycle, mem_addr=1, next cycle f_rvalid=1, f_rdata=0x00000063, no l_* activity.
- l_req write addr 0x10 data 0xDEADBEEF, no fetch -> l_gnt, mem_we=1, mem_addr=2; then loader read 0x10 -> l_rvalid next cycle with 0xDEADBEEF.
- f_req held continuously with l_req read, STARVE_LIMIT=4 -> fetch granted cycles 0-3, loader granted cycle 4, counter clears, fetch granted cycle 5.
- l_lock=1 with f_req=1, l_req=0 -> f_gnt=0, mem_en=0 for 10 cycles; drop l_lock -> fetch granted the same cycle.
- Bad addresses, f_addr=0x4 and l_addr=0x400 in the same cycle -> both gnt, mem_en=0, next cycle f_err=l_err=1, rvalid=1, rdata=0.
- Granted fetch read, rst asserted the next cycle -> f_rvalid=0 in that and all following cycles until a new grant.
